// File: rtl/seq_booth_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_booth_multiplier_if
//  Description : Operand/result handshake bundle for seq_booth_multiplier.
//                The master drives operands and consumes the product. The
//                slave is the multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_booth_multiplier_if #(
   parameter int WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 is_signed;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   // Operand issue stage and result consumer
   modport master (
      output in_valid,
      input  in_ready,
      output is_signed,
      output multiplicand,
      output multiplier,
      input  out_valid,
      output out_ready,
      input  product,
      input  busy
   );

   // Multiplier side
   modport slave (
      input  in_valid,
      output in_ready,
      input  is_signed,
      input  multiplicand,
      input  multiplier,
      output out_valid,
      input  out_ready,
      output product,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/seq_booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_booth_multiplier
//  Description : Iterative Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, with
//                per-operation signed/unsigned selection and valid/ready
//                handshakes on both sides. One operation in flight.
//                WIDTH must be even and within 4..64.
//  Build macro : SEQ_BOOTH_MULT_RADIX4_EN
//                  defined   -> radix-4 modified Booth, K = (WIDTH+2)/2 steps
//                  undefined -> radix-2 Booth,          K =  WIDTH+2    steps
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_booth_multiplier #(
   parameter int WIDTH = 32
) (
   input  wire                  clk,
   input  wire                  rst,
   seq_booth_multiplier_if.slave bus
);

   // Operands are widened by two bits so that both signed and unsigned
   // inputs become ordinary two's complement values of width c_E. The
   // Booth recoding of the c_E-bit multiplier is then exact in both modes.
   localparam int c_E = WIDTH + 2;

`ifdef SEQ_BOOTH_MULT_RADIX4_EN
   localparam int c_K = c_E / 2;
`else
   localparam int c_K = c_E;
`endif

   localparam int                   c_CNT_W = $clog2(c_K + 1);
   localparam logic [c_CNT_W-1:0]   c_K_CNT = c_CNT_W'(c_K);
   localparam logic [c_CNT_W-1:0]   c_ONE   = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [c_E-1:0]        r_mcand;     // extended multiplicand A
   logic [2*c_E-1:0]      r_acc;       // {partial product, remaining multiplier}
   logic                  r_guard;     // Booth guard bit q(-1)
   logic [c_CNT_W-1:0]    r_cnt;       // steps still to perform
   logic [2*WIDTH-1:0]    r_product;

   logic [c_E:0]          w_a_ext;     // A widened to the internal sum width
   logic [c_E:0]          w_p_ext;     // upper accumulator half, sign-widened
   logic [c_E:0]          w_addend;    // selected Booth multiple of A
   logic [c_E:0]          w_sum;
   logic [2*c_E-1:0]      w_acc_nxt;
   logic                  w_guard_nxt;
   logic                  w_last_step;

   // Operand widening: sign or zero extension by two bits
   logic [c_E-1:0]        w_mcand_ext;
   logic [c_E-1:0]        w_mplier_ext;

   assign w_mcand_ext  = {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
   assign w_mplier_ext = {{2{bus.is_signed & bus.multiplier[WIDTH-1]}},   bus.multiplier};

   assign w_last_step  = (r_cnt == c_ONE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake outputs; outputs depend on state only
   always_comb begin
      w_state_nxt   = r_state;
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            bus.busy = 1'b1;
            if (w_last_step) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // One Booth step: select the multiple of A, add it to the upper half and
   // shift the whole accumulator right arithmetically. The sum is one bit
   // wider than the accumulator half so that +/-2A can never overflow.
   always_comb begin
      w_a_ext     = {r_mcand[c_E-1], r_mcand};
      w_p_ext     = {r_acc[2*c_E-1], r_acc[2*c_E-1:c_E]};
      w_addend    = '0;
`ifdef SEQ_BOOTH_MULT_RADIX4_EN
      case ({r_acc[1:0], r_guard})
         3'b001, 3'b010: w_addend = w_a_ext;
         3'b011:         w_addend = w_a_ext << 1;
         3'b100:         w_addend = -(w_a_ext << 1);
         3'b101, 3'b110: w_addend = -w_a_ext;
         default:        w_addend = '0;
      endcase
      w_sum       = w_p_ext + w_addend;
      w_acc_nxt   = {w_sum[c_E], w_sum, r_acc[c_E-1:2]};
      w_guard_nxt = r_acc[1];
`else
      case ({r_acc[0], r_guard})
         2'b01:   w_addend = w_a_ext;
         2'b10:   w_addend = -w_a_ext;
         default: w_addend = '0;
      endcase
      w_sum       = w_p_ext + w_addend;
      w_acc_nxt   = {w_sum, r_acc[c_E-1:1]};
      w_guard_nxt = r_acc[0];
`endif
   end

   // Datapath registers: operand capture, iteration and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand   <= '0;
         r_acc     <= '0;
         r_guard   <= 1'b0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_mcand <= w_mcand_ext;
                  r_acc   <= {{c_E{1'b0}}, w_mplier_ext};
                  r_guard <= 1'b0;
                  r_cnt   <= c_K_CNT;
               end
            end
            ST_RUN: begin
               r_acc   <= w_acc_nxt;
               r_guard <= w_guard_nxt;
               r_cnt   <= r_cnt - c_ONE;
               if (w_last_step) begin
                  r_product <= w_acc_nxt[2*WIDTH-1:0];
               end
            end
            default: begin
               // DONE holds everything; the product persists after transfer
            end
         endcase
      end
   end

   assign bus.product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_booth_multiplier
//  Description : Self-checking bench for seq_booth_multiplier (WIDTH=32).
//                Directed vector table, backpressure and mid-operation
//                reset sequences, then randomized operations with random
//                consumer stalls against an arithmetic reference model.
//                Works with or without SEQ_BOOTH_MULT_RADIX4_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_booth_multiplier;

   localparam int WIDTH = 32;
`ifdef SEQ_BOOTH_MULT_RADIX4_EN
   localparam int K = (WIDTH + 2) / 2;
`else
   localparam int K = WIDTH + 2;
`endif

   logic clk;
   logic rst;

   seq_booth_multiplier_if #(.WIDTH(WIDTH)) bus ();

   seq_booth_multiplier #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[10];

   logic [63:0] exp_q[$];

   // Exact product of the two operands interpreted per the mode
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
      longint      sa;
      longint      sb;
      logic [63:0] ua;
      logic [63:0] ub;
      if (s) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
         return 64'(sa * sb);
      end
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
   endfunction

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after acceptance
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s);
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.is_signed    = s;
      bus.in_valid     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid     = 1'b0;
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
      bus.is_signed    = 1'($urandom_range(0, 1));
   endtask

   // Counts edges after acceptance until out_valid is seen (bounded)
   task automatic wait_done(output int lat);
      lat = 0;
      forever begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.out_valid === 1'b1) break;
         if (lat > 4 * K) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_done: out_valid not seen after %0d edges, expected %0d", lat, K);
            break;
         end
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int          lat;
      logic [63:0] held;
      logic [63:0] got;
      logic [63:0] exp;
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      bit          done;
      bit          ready_seen;
      int          n_xfer;
      int          n_dup;

      vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
      vecs[1] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000};
      vecs[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};
      vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
      vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
      vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
      vecs[6] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0000000000000000};
      vecs[7] = '{32'h00000003, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFFFFFFFFF1};
      vecs[8] = '{32'h00000003, 32'hFFFFFFFB, 1'b0, 64'h00000002FFFFFFF1};
      vecs[9] = '{32'h12345678, 32'h00000010, 1'b0, 64'h0000000123456780};

      rst              = 1'b1;
      bus.in_valid     = 1'b0;
      bus.is_signed    = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      bus.out_ready    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check1 ("reset_in_ready",  bus.in_ready,  1'b1);
      check1 ("reset_out_valid", bus.out_valid, 1'b0);
      check1 ("reset_busy",      bus.busy,      1'b0);
      check64("reset_product",   bus.product,   64'h0);

      // Directed vectors, consumer always ready
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].s);
         if (i == 0) check1("busy_in_run", bus.busy, 1'b1);
         wait_done(lat);
         check_int($sformatf("latency_v%0d", i), lat, K);
         check64($sformatf("product_v%0d", i), bus.product, vecs[i].exp);
         @(posedge clk);
         @(negedge clk);
         check1($sformatf("in_ready_after_v%0d", i), bus.in_ready, 1'b1);
      end

      // Backpressure: result held for 10 cycles, new request ignored
      bus.out_ready = 1'b0;
      issue(32'h00000007, 32'hFFFFFFFA, 1'b1);
      wait_done(lat);
      held = bus.product;
      check64("bp_product", held, 64'hFFFFFFFFFFFFFFD6);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus.in_valid     = 1'b1;
            bus.multiplicand = 32'h00000005;
            bus.multiplier   = 32'h00000009;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         check1 ($sformatf("bp_out_valid_%0d", i), bus.out_valid, 1'b1);
         check1 ($sformatf("bp_in_ready_%0d", i),  bus.in_ready,  1'b0);
         check64($sformatf("bp_stable_%0d", i),    bus.product,   held);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check1 ("bp_release_in_ready",  bus.in_ready,  1'b1);
      check1 ("bp_release_out_valid", bus.out_valid, 1'b0);
      check64("bp_product_kept",      bus.product,   held);
      @(posedge clk);
      @(negedge clk);
      check1("bp_ignored_request", bus.busy, 1'b0);
      bus.out_ready = 1'b1;

      // Reset on the fifth iteration edge of 2*3
      issue(32'h00000002, 32'h00000003, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check1 ("midrst_out_valid", bus.out_valid, 1'b0);
      check64("midrst_product",   bus.product,   64'h0);
      check1 ("midrst_in_ready",  bus.in_ready,  1'b1);
      check1 ("midrst_busy",      bus.busy,      1'b0);
      ready_seen = 1'b0;
      repeat (K + 2) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid === 1'b1) ready_seen = 1'b1;
      end
      check1("midrst_no_stale_result", ready_seen, 1'b0);
      issue(32'h00000002, 32'hFFFFFFFE, 1'b1);
      wait_done(lat);
      check_int("midrst_next_latency", lat, K);
      check64("midrst_next_product", bus.product, 64'hFFFFFFFFFFFFFFFC);
      @(posedge clk);
      @(negedge clk);

      // Randomized operations with random consumer stalls
      n_xfer = 0;
      n_dup  = 0;
      for (int n = 0; n < 200; n++) begin
         a = $urandom;
         b = $urandom;
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: a = 32'h80000000;
            1: b = 32'hFFFFFFFF;
            2: a = 32'hFFFFFFFF;
            default: ;
         endcase
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            @(negedge clk);
         end
         ready_seen = 1'b0;
         for (int w = 0; w < 5 && !ready_seen; w++) begin
            if (bus.in_ready === 1'b1) ready_seen = 1'b1;
            else begin
               @(posedge clk);
               @(negedge clk);
            end
         end
         if (!ready_seen) begin
            check1("rand_in_ready_timeout", bus.in_ready, 1'b1);
            break;
         end
         exp_q.push_back(model(a, b, s));
         issue(a, b, s);
         done = 1'b0;
         for (int c = 0; c < 8 * K && !done; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
               got = bus.product;
               exp = exp_q.pop_front();
               check64($sformatf("rand_product_%0d", n), got, exp);
               n_xfer++;
               done = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
         end
         if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL rand_timeout_%0d: result not transferred, expected 0x%016h", n, exp_q[0]);
            break;
         end
         if (bus.out_valid !== 1'b0) n_dup++;
      end
      bus.out_ready = 1'b1;
      check_int("rand_transfers",  n_xfer,        200);
      check_int("rand_duplicates", n_dup,         0);
      check_int("rand_pending",    exp_q.size(),  0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
